// File: rtl/mul_multicycle.sv
// Fixed-latency 32x32->64 multiplier with per-operand signedness for MUL/MULH/MULHSU/MULHU.
// Optional macro MUL_ZERO_SKIP_EN: a zero operand at the start edge completes in one cycle.
module mul_multicycle #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        sign0,
  input  logic        sign1,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic        done,
  output logic [63:0] result
);

  localparam int unsigned DATA_W = 32;
  localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q;

  logic [DATA_W-1:0] m_p0, r_p0;
  logic              sign_m_p0, sign_r_p0;

  logic        start, zero_skip, finish_busy, load_result;
  logic [DATA_W-1:0] op_m, op_r;
  logic        op_sign_m, op_sign_r;
  logic [63:0] product;

  function automatic logic signed [63:0] ext_op(input logic [DATA_W-1:0] v,
                                                input logic is_signed);
    logic signed [63:0] e;
    e = is_signed ? {{(64-DATA_W){v[DATA_W-1]}}, v} : {{(64-DATA_W){1'b0}}, v};
    return e;
  endfunction

  function automatic logic [63:0] mul_low(input logic signed [63:0] a,
                                          input logic signed [63:0] b);
    logic signed [63:0] p;
    p = a * b;
    return $unsigned(p);
  endfunction

  assign start = (state_q == S_IDLE) && go;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_skip = start && ((m == '0) || (r == '0));
`else
  assign zero_skip = 1'b0;
`endif

  assign finish_busy = (state_q == S_BUSY) && go && (cnt_q == LAST_CNT);
  assign load_result = (start && ((LATENCY == 1) || zero_skip)) || finish_busy;

  // On the start edge the live operands are the ones being captured.
  assign op_m      = (state_q == S_IDLE) ? m     : m_p0;
  assign op_r      = (state_q == S_IDLE) ? r     : r_p0;
  assign op_sign_m = (state_q == S_IDLE) ? sign1 : sign_m_p0;
  assign op_sign_r = (state_q == S_IDLE) ? sign0 : sign_r_p0;
  assign product   = mul_low(ext_op(op_m, op_sign_m), ext_op(op_r, op_sign_r));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = ((LATENCY == 1) || zero_skip) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!go) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= 4'd1;
    end else if ((state_q == S_BUSY) && go) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Operand capture stage: held constant for the whole operation.
  always_ff @(posedge clk) begin
    if (start) begin
      m_p0      <= m;
      r_p0      <= r;
      sign_m_p0 <= sign1;
      sign_r_p0 <= sign0;
    end
  end

  // Result stage: loaded only on completion, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
    end else if (load_result) begin
      result <= zero_skip ? 64'd0 : product;
    end
  end

endmodule

// File: tb/tb_mul_multicycle.sv
// Directed bench for mul_multicycle: scoreboard queue of expected products,
// latency checked against the cycle in which go was first presented.
module tb_mul_multicycle;

  localparam int LAT = 4;
`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = LAT;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic        sign0;
  logic        sign1;
  logic [31:0] m;
  logic [31:0] r;
  logic        done;
  logic [63:0] result;

  int          total    = 0;
  int          pass_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result;

  mul_multicycle #(.LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go),
    .sign0   (sign0),
    .sign1   (sign1),
    .m       (m),
    .r       (r),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
  endtask

  // sign1 selects m signedness, sign0 selects r signedness.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s0, input logic s1);
    longint x, y;
    x = s1 ? longint'($signed(a)) : longint'(a);
    y = s0 ? longint'($signed(b)) : longint'(b);
    return 64'(x * y);
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s0, input logic s1,
                          input logic [63:0] exp, input bit track);
    m     = a;
    r     = b;
    sign0 = s0;
    sign1 = s1;
    go    = 1'b1;
    if (track) exp_q.push_back(exp);
  endtask

  // Called in the cycle numbered k0 (just after a rising edge); waits for done.
  task automatic wait_done(input string tag, input int exp_cycle, input int k0);
    int          k;
    bit          found;
    logic [63:0] exp;
    k     = k0;
    found = 1'b0;
    while (!found && k <= exp_cycle + 4) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check({tag, " done seen"}, 64'(found), 64'd1);
    if (found) begin
      check({tag, " latency"}, 64'(k), 64'(exp_cycle));
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = 'x;
      check({tag, " result"}, result, exp);
      last_result = exp;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit          saw;
    logic [31:0] a, b;
    logic        s0, s1;

    reset_n = 1'b0;
    go = 1'b0; sign0 = 1'b0; sign1 = 1'b0; m = '0; r = '0;
    last_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 7*6, then go kept high into a back-to-back 3*5
    start_op(32'd7, 32'd6, 1'b0, 1'b0, 64'h2A, 1'b1);
    wait_done("t1 7x6", 4, 0);
    start_op(32'd3, 32'd5, 1'b0, 1'b0, 64'hF, 1'b1);
    wait_done("t3 back2back", 4, 0);
    go = 1'b0;

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 1'b1);
    wait_done("t2 ss", 4, 0);
    go = 1'b0;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_done("t2 uu", 4, 0);
    go = 1'b0;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001, 1'b1);
    wait_done("t2 su", 4, 0);
    go = 1'b0;
    start_op(32'h8000_0000, 32'd3, 1'b1, 1'b0, 64'h0000_0001_8000_0000, 1'b1);
    wait_done("t2 us", 4, 0);
    go = 1'b0;

    // operand change during BUSY must be ignored
    start_op(32'h10, 32'h10, 1'b0, 1'b0, 64'h100, 1'b1);
    @(posedge clk);
    #1;
    m = 32'h1234;
    wait_done("t5 opchange", 4, 1);
    go = 1'b0;

    // abort by dropping go in cycle 2
    start_op(32'd2, 32'd2, 1'b0, 1'b0, 64'd4, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    go = 1'b0;
    saw = 1'b0;
    repeat (8) begin @(negedge clk); if (done !== 1'b0) saw = 1'b1; end
    check("abort no done", 64'(saw), 64'd0);
    check("abort result kept", result, last_result);
    @(posedge clk);
    #1;

    // asynchronous reset in cycle 2
    start_op(32'd2, 32'd2, 1'b0, 1'b0, 64'd4, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    #3;
    reset_n = 1'b0;
    go = 1'b0;
    #1;
    check("async reset done", 64'(done), 64'd0);
    check("async reset result", result, 64'd0);
    #1;
    reset_n = 1'b1;
    last_result = '0;
    saw = 1'b0;
    repeat (8) begin @(negedge clk); if (done !== 1'b0) saw = 1'b1; end
    check("post reset no done", 64'(saw), 64'd0);
    @(posedge clk);
    #1;

    // zero operand
    start_op(32'd0, 32'h55, 1'b0, 1'b0, 64'd0, 1'b1);
    wait_done("t6 zero", ZLAT, 0);
    go = 1'b0;

    for (int i = 0; i < 4; i++) begin
      a  = $urandom;
      b  = $urandom;
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      if (a == 32'd0) a = 32'd1;
      if (b == 32'd0) b = 32'd1;
      start_op(a, b, s0, s1, model(a, b, s0, s1), 1'b1);
      wait_done("rand", LAT, 0);
      go = 1'b0;
    end

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
